// File: rtl/mem_access_stage.sv
// Purpose : MEM pipeline stage. Issues data-memory loads/stores over a req/ack
//           bus, resolves branches and registers the MEM/WB outputs.
// Latency : non-memory ops 1 cycle; memory ops 1 + cycles until dmem_ack.
// Backpressure: stall_out holds EX/MEM while a request is being issued or is
//           outstanding. Requests that get no ack are aborted after ACK_TIMEOUT
//           cycles. ACK_TIMEOUT = 0 disables the abort.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   valid_in .. regwrite_in        EX/MEM pipeline register contents
//   stall_out, pc_src, branch_target   upstream hazard/branch controls (combinational)
//   dmem_req/we/addr/wdata         registered memory request
//   dmem_rdata, dmem_ack           memory response (ack is a single-cycle completion)
//   wb_*                           registered MEM/WB outputs
//   misalign_err, bus_err          one-cycle error pulses
module mem_access_stage #(
  parameter int XLEN        = 64,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            zero_in,
  input  logic            branch_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] write_data_in,
  input  logic [4:0]      write_reg_in,
  input  logic            memread_in,
  input  logic            memwrite_in,
  input  logic            memtoreg_in,
  input  logic            regwrite_in,
  output logic            stall_out,
  output logic            pc_src,
  output logic [XLEN-1:0] branch_target,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_read_data,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [4:0]      wb_write_reg,
  output logic            wb_memtoreg,
  output logic            wb_regwrite,
  output logic            misalign_err,
  output logic            bus_err
);

  // Counter is at least one bit wide so ACK_TIMEOUT = 0 still elaborates.
  localparam int CW   = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);
  localparam bit TO_EN = (ACK_TIMEOUT != 0);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [4:0]      dst_q, dst_d;
  logic            m2r_q, m2r_d;
  logic            rw_q, rw_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_rdata_q, wb_rdata_d;
  logic [XLEN-1:0] wb_alu_q, wb_alu_d;
  logic [4:0]      wb_reg_q, wb_reg_d;
  logic            wb_m2r_q, wb_m2r_d;
  logic            wb_rw_q, wb_rw_d;
  logic            misalign_q, misalign_d;
  logic            buserr_q, buserr_d;

  logic memop, aligned, timeout;

  assign memop   = valid_in & (memread_in | memwrite_in);
  assign aligned = (alu_result_in[2:0] == 3'b000);
  // An ack arriving in the last allowed cycle takes priority over the abort.
  assign timeout = TO_EN && (state_q == WAIT) && !dmem_ack && (cnt_q == CNT_LAST);

  assign stall_out = ((state_q == IDLE) & memop & aligned) |
                     ((state_q == WAIT) & ~dmem_ack);
  assign pc_src        = valid_in & branch_in & zero_in & ~stall_out;
  assign branch_target = pc_in;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dst_d      = dst_q;
    m2r_d      = m2r_q;
    rw_d       = rw_q;
    wb_valid_d = 1'b0;
    wb_rdata_d = wb_rdata_q;
    wb_alu_d   = wb_alu_q;
    wb_reg_d   = wb_reg_q;
    wb_m2r_d   = wb_m2r_q;
    wb_rw_d    = 1'b0;
    misalign_d = 1'b0;
    buserr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (memop && aligned) begin
          // Capture the access; the request goes out from the next cycle and
          // MEM/WB receives a bubble meanwhile.
          state_d = WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = memwrite_in;  // read+write together is treated as a store
          addr_d  = alu_result_in;
          wdata_d = write_data_in;
          dst_d   = write_reg_in;
          m2r_d   = memtoreg_in;
          rw_d    = regwrite_in;
        end else if (valid_in) begin
          // Non-memory op, or a misaligned memory op that retires without a
          // request and without a register write.
          wb_valid_d = 1'b1;
          wb_rdata_d = '0;
          wb_alu_d   = alu_result_in;
          wb_reg_d   = write_reg_in;
          wb_m2r_d   = memtoreg_in;
          wb_rw_d    = regwrite_in & ~memop;
          misalign_d = memop;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (dmem_ack) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rdata_d = we_q ? '0 : dmem_rdata;
          wb_alu_d   = addr_q;
          wb_reg_d   = dst_q;
          wb_m2r_d   = m2r_q;
          wb_rw_d    = rw_q;
        end else if (timeout) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rdata_d = '0;
          wb_alu_d   = addr_q;
          wb_reg_d   = dst_q;
          wb_m2r_d   = m2r_q;
          wb_rw_d    = 1'b0;
          buserr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dst_q      <= '0;
      m2r_q      <= 1'b0;
      rw_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rdata_q <= '0;
      wb_alu_q   <= '0;
      wb_reg_q   <= '0;
      wb_m2r_q   <= 1'b0;
      wb_rw_q    <= 1'b0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dst_q      <= dst_d;
      m2r_q      <= m2r_d;
      rw_q       <= rw_d;
      wb_valid_q <= wb_valid_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
      wb_reg_q   <= wb_reg_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rw_q    <= wb_rw_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_read_data  = wb_rdata_q;
  assign wb_alu_result = wb_alu_q;
  assign wb_write_reg  = wb_reg_q;
  assign wb_memtoreg   = wb_m2r_q;
  assign wb_regwrite   = wb_rw_q;
  assign misalign_err  = misalign_q;
  assign bus_err       = buserr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Purpose : stimulus and transaction-level reference checks for mem_access_stage.
// Latency : follows the DUT; each instruction is retired before the next is driven.
// Backpressure: the bench acts as upstream and holds controls while stalled.
module tb_mem_access_stage;
  localparam int XLEN = 64;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_in = 1'b0;
  logic [XLEN-1:0] pc_in = '0;
  logic            zero_in = 1'b0;
  logic            branch_in = 1'b0;
  logic [XLEN-1:0] alu_result_in = '0;
  logic [XLEN-1:0] write_data_in = '0;
  logic [4:0]      write_reg_in = '0;
  logic            memread_in = 1'b0;
  logic            memwrite_in = 1'b0;
  logic            memtoreg_in = 1'b0;
  logic            regwrite_in = 1'b0;
  logic            stall_out, pc_src;
  logic [XLEN-1:0] branch_target;
  logic            dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata;
  logic [XLEN-1:0] dmem_rdata = '0;
  logic            dmem_ack = 1'b0;
  logic            wb_valid;
  logic [XLEN-1:0] wb_read_data, wb_alu_result;
  logic [4:0]      wb_write_reg;
  logic            wb_memtoreg, wb_regwrite, misalign_err, bus_err;

  mem_access_stage #(.XLEN(XLEN), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in),
    .zero_in(zero_in), .branch_in(branch_in), .alu_result_in(alu_result_in),
    .write_data_in(write_data_in), .write_reg_in(write_reg_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
    .stall_out(stall_out), .pc_src(pc_src), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_write_reg(wb_write_reg),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Applies one instruction (called #1 after a rising edge) and checks it to
  // retirement. ack_dly = WAIT cycle in which the memory answers; a negative or
  // >= TO value means the memory never answers. spur drives a stray ack while idle.
  task automatic do_instr(input logic v, input logic br, input logic z,
                          input logic mr, input logic mw, input logic m2r,
                          input logic rw, input logic [63:0] pc,
                          input logic [63:0] alu, input logic [63:0] wd,
                          input logic [4:0] rd, input int ack_dly,
                          input logic [63:0] rdata, input logic spur);
    logic memop, al, done;
    valid_in = v; branch_in = br; zero_in = z; memread_in = mr; memwrite_in = mw;
    memtoreg_in = m2r; regwrite_in = rw; pc_in = pc; alu_result_in = alu;
    write_data_in = wd; write_reg_in = rd;
    memop = v & (mr | mw);
    al    = (alu % 8) == 0;
    done  = 1'b0;
    if (memop && al) begin
      dmem_ack = 1'b0;
      @(negedge clk);
      check_eq("issue_stall", stall_out, 1);
      check_eq("issue_pcsrc", pc_src, 0);
      check_eq("issue_noreq", dmem_req, 0);
      @(posedge clk); #1;
      check_eq("wait_wbvalid", wb_valid, 0);
      for (int k = 0; k < TO && !done; k++) begin
        // Data fields change underneath; the DUT must use what it captured.
        alu_result_in = rnd64() & ~64'h7;
        write_data_in = rnd64();
        write_reg_in  = 5'($urandom());
        if (k == ack_dly) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
        @(negedge clk);
        check_eq("wait_stall", stall_out, (k != ack_dly));
        check_eq("wait_pcsrc", pc_src, v & br & z & (k == ack_dly));
        check_eq("wait_req", dmem_req, 1);
        check_eq("wait_we", dmem_we, mw);
        check_eq("wait_addr", dmem_addr, alu);
        check_eq("wait_wdata", dmem_wdata, wd);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        if (k == ack_dly) done = 1'b1;
      end
      check_eq("done_req", dmem_req, 0);
      check_eq("done_wbvalid", wb_valid, 1);
      check_eq("done_alu", wb_alu_result, alu);
      check_eq("done_reg", wb_write_reg, rd);
      check_eq("done_m2r", wb_memtoreg, m2r);
      check_eq("done_misalign", misalign_err, 0);
      if (done) begin
        check_eq("ack_rdata", wb_read_data, mw ? 64'd0 : rdata);
        check_eq("ack_regwrite", wb_regwrite, rw);
        check_eq("ack_buserr", bus_err, 0);
      end else begin
        check_eq("to_rdata", wb_read_data, 0);
        check_eq("to_regwrite", wb_regwrite, 0);
        check_eq("to_buserr", bus_err, 1);
      end
    end else begin
      dmem_ack = spur;
      dmem_rdata = rnd64();
      @(negedge clk);
      check_eq("pass_stall", stall_out, 0);
      check_eq("pass_pcsrc", pc_src, v & br & z);
      check_eq("pass_target", branch_target, pc);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check_eq("pass_wbvalid", wb_valid, v);
      check_eq("pass_regwrite", wb_regwrite, v & rw & ~memop);
      check_eq("pass_misalign", misalign_err, memop);
      check_eq("pass_req", dmem_req, 0);
      check_eq("pass_buserr", bus_err, 0);
      if (v) begin
        check_eq("pass_alu", wb_alu_result, alu);
        check_eq("pass_reg", wb_write_reg, rd);
        check_eq("pass_m2r", wb_memtoreg, m2r);
        check_eq("pass_rdata", wb_read_data, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check_eq("rst_req", dmem_req, 0);
    check_eq("rst_wbvalid", wb_valid, 0);
    check_eq("rst_stall", stall_out, 0);
    check_eq("rst_bus", {dmem_we, misalign_err, bus_err, wb_regwrite, wb_memtoreg}, 0);
    check_eq("rst_addr", dmem_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_instr(1, 0, 0, 0, 0, 0, 1, 64'h0,   64'h2A,  64'h0,  5'd5,  0, 64'h0, 0);
    do_instr(1, 0, 0, 1, 0, 1, 1, 64'h0,   64'h100, 64'h0,  5'd7,  3, 64'hDEADBEEF, 0);
    do_instr(1, 0, 0, 0, 1, 0, 0, 64'h0,   64'h108, 64'h55, 5'd0,  2, 64'h1234, 0);
    do_instr(1, 0, 0, 1, 0, 1, 1, 64'h0,   64'h103, 64'h0,  5'd9,  0, 64'h0, 0);
    do_instr(1, 0, 0, 1, 0, 1, 1, 64'h0,   64'h200, 64'h0,  5'd3, -1, 64'h0, 0);
    do_instr(1, 0, 0, 1, 0, 1, 1, 64'h0,   64'h208, 64'h0,  5'd4, TO-1, 64'hCAFE, 0);
    do_instr(1, 0, 0, 1, 1, 0, 1, 64'h0,   64'h210, 64'h77, 5'd6,  0, 64'hBAD, 0);
    do_instr(1, 1, 1, 0, 0, 0, 0, 64'h400, 64'h0,   64'h0,  5'd0,  0, 64'h0, 0);
    do_instr(1, 1, 0, 0, 0, 0, 0, 64'h400, 64'h1,   64'h0,  5'd0,  0, 64'h0, 0);
    do_instr(0, 0, 0, 0, 0, 0, 1, 64'h0,   64'h0,   64'h0,  5'd1,  0, 64'h0, 1);

    // Reset while a load is outstanding
    valid_in = 1; memread_in = 1; memwrite_in = 0; regwrite_in = 1; alu_result_in = 64'h300;
    @(posedge clk); #1;
    check_eq("mid_req_on", dmem_req, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_req_off", dmem_req, 0);
    check_eq("mid_addr", dmem_addr, 0);
    check_eq("mid_wbvalid", wb_valid, 0);
    valid_in = 0; memread_in = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_req", dmem_req, 0);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      int kind, dly;
      logic v, br, z, mr, mw;
      logic [63:0] alu;
      kind = $urandom_range(0, 7);
      v  = (kind != 0);
      br = (kind == 3) || ($urandom_range(0, 7) == 0);
      z  = $urandom_range(0, 1);
      mr = (kind == 4) || (kind == 5) || (kind == 7);
      mw = (kind == 6) || (kind == 7);
      alu = rnd64();
      if ($urandom_range(0, 3) != 0) alu = alu & ~64'h7;
      dly = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5);
      do_instr(v, br, z, mr, mw, 1'($urandom()), 1'($urandom()), rnd64(), alu,
               rnd64(), 5'($urandom()), dly, rnd64(), 1'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
